// File: rtl/key_event_arbiter.sv
// key_event_arbiter: latches one-cycle button edge pulses as pending events,
// grants them round-robin and presents one at a time over valid/ready.
// After each accepted event the arbiter rests for a holdoff window so that,
// with the consumer always ready, events complete GAP+3 cycles apart.
module key_event_arbiter #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int GAP  = 16,
  parameter int GAPW = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   edge_in,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   dropped,
  input  logic           clear_dropped
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    HOLDOFF
  } state_t;

  state_t         state;
  logic [N-1:0]   pending;
  logic [GAPW-1:0] gap_cnt;
  logic [IDW-1:0] last_grant;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           grant_fire;
  logic [N-1:0]   grant_mask;
  logic [N-1:0]   new_drops;

  // Round-robin search: first pending bit from last_grant+1, wrapping back to last_grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!grant_found && pending[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // A grant only happens from IDLE; its mask clears the pending bit and shields it from a drop.
  always_comb begin
    grant_fire = (state == IDLE) && grant_found;
    grant_mask = grant_fire ? (N'(1) << grant_idx) : '0;
    new_drops  = edge_in & pending & ~grant_mask;
  end

  // Pending bits and the sticky drop flags; a new drop wins over clear_dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      dropped <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | edge_in;
      dropped <= (clear_dropped ? '0 : dropped) | new_drops;
    end
  end

  // Grant/present/holdoff sequencer; holdoff counts GAP down to 0 so the window is GAP+1 cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      gap_cnt    <= '0;
      last_grant <= IDW'(N-1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            state      <= PRESENT;
            evt_valid  <= 1'b1;
            evt_id     <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            if (GAP > 0) begin
              state   <= HOLDOFF;
              gap_cnt <= GAPW'(GAP);
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLDOFF: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAPW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: table vectors, directed corner sequences and a
// randomized run, all checked against a time-based behavioural model.
module tb_key_event_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int GAP  = 16;
  localparam int GAPW = 8;

  logic           clock;
  logic           reset;
  logic [N-1:0]   edge_in;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   dropped;
  logic           clear_dropped;

  int checks;
  int failures;

  key_event_arbiter #(.N(N), .IDW(IDW), .GAP(GAP), .GAPW(GAPW)) dut (
    .clock         (clock),
    .reset         (reset),
    .edge_in       (edge_in),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_id        (evt_id),
    .dropped       (dropped),
    .clear_dropped (clear_dropped)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: pending set, drop flags, the event being shown,
  // round-robin pointer and the earliest cycle a new grant may be made.
  bit [N-1:0] m_pend;
  bit [N-1:0] m_drop;
  bit         m_valid;
  int         m_id;
  int         m_last;
  int         m_earliest;
  int         cyc;

  typedef struct packed {
    logic       rst;
    logic [3:0] edge_v;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_drop;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    int  g;
    bit  hs;
    bit [N-1:0] nd;
    if (reset) begin
      m_pend     = '0;
      m_drop     = '0;
      m_valid    = 1'b0;
      m_id       = 0;
      m_last     = N - 1;
      m_earliest = 0;
    end else begin
      g = -1;
      if (!m_valid && cyc >= m_earliest) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
        end
      end
      hs = m_valid && evt_ready;
      nd = '0;
      for (int i = 0; i < N; i++) begin
        if (g == i) begin
          m_pend[i] = edge_in[i];
        end else if (edge_in[i]) begin
          if (m_pend[i]) nd[i] = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
      m_drop = (clear_dropped ? '0 : m_drop) | nd;
      if (g >= 0) begin
        m_valid = 1'b1;
        m_id    = g;
        m_last  = g;
      end else if (hs) begin
        m_valid    = 1'b0;
        m_earliest = (GAP == 0) ? cyc + 1 : cyc + GAP + 2;
      end
    end
    cyc++;
  endtask

  task automatic check_output();
    check("model_valid",   evt_valid,   m_valid);
    check("model_id",      evt_id,      m_id);
    check("model_dropped", dropped,     m_drop);
    check("model_pending", dut.pending, m_pend);
  endtask

  task automatic apply_stimulus(input logic rst, input logic [N-1:0] e, input logic rdy, input logic clr);
    reset         = rst;
    edge_in       = e;
    evt_ready     = rdy;
    clear_dropped = clr;
    model_step();
    @(posedge clock);
    #1;
    check_output();
  endtask

  task automatic wait_valid(input int max_cycles, input logic rdy);
    int n;
    n = 0;
    while (!evt_valid && n < max_cycles) begin
      apply_stimulus(1'b0, '0, rdy, 1'b0);
      n++;
    end
    check("wait_valid", evt_valid, 1);
  endtask

  // Watchdog: never let the run hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_rise;
    int rise_cyc [3];
    int rise_id  [3];
    logic prev;
    logic stable;
    logic [N-1:0] e;

    checks = 0;
    failures = 0;
    cyc = 0;
    m_pend = '0; m_drop = '0; m_valid = 0; m_id = 0; m_last = N - 1; m_earliest = 0;
    reset = 1'b1; edge_in = '0; evt_ready = 1'b0; clear_dropped = 1'b0;

    //            rst   edge     rdy   clr   valid id    drop
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000};
    vecs[6]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0010};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[10] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].edge_v, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), evt_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_id", i),    evt_id,    vecs[i].exp_id);
      check($sformatf("vec%0d_drop", i),  dropped,   vecs[i].exp_drop);
    end

    $display("[TB] simultaneous edges on 0,1,3");
    apply_stimulus(1'b1, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b1011, 1'b1, 1'b0);
    n_rise = 0;
    prev = 1'b0;
    for (int k = 0; k < 3; k++) begin rise_cyc[k] = -100; rise_id[k] = -1; end
    for (int c = 0; c < 100; c++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      if (evt_valid && !prev) begin
        if (n_rise < 3) begin rise_cyc[n_rise] = c; rise_id[n_rise] = int'(evt_id); end
        n_rise++;
      end
      prev = evt_valid;
    end
    check("t2_count", n_rise, 3);
    check("t2_id0", rise_id[0], 0);
    check("t2_id1", rise_id[1], 1);
    check("t2_id2", rise_id[2], 3);
    check("t2_first_latency", rise_cyc[0], 0);
    check("t2_spacing01", rise_cyc[1] - rise_cyc[0], GAP + 3);
    check("t2_spacing12", rise_cyc[2] - rise_cyc[1], GAP + 3);

    $display("[TB] stalled consumer on button 1");
    apply_stimulus(1'b1, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b0010, 1'b0, 1'b0);
    wait_valid(10, 1'b0);
    check("t3_id", evt_id, 1);
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      e = (c == 20 || c == 30) ? 4'b0010 : 4'b0000;
      apply_stimulus(1'b0, e, 1'b0, 1'b0);
      if (!(evt_valid && evt_id == 2'd1)) stable = 1'b0;
      if (c == 20) check("t3_first_extra_no_drop", dropped[1], 0);
      if (c == 30) check("t3_second_extra_drop", dropped[1], 1);
    end
    check("t3_stable", stable, 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check("t3_released", evt_valid, 0);

    $display("[TB] edge on button 0 during its own grant");
    apply_stimulus(1'b1, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0);
    check("t4_first_valid", evt_valid, 1);
    check("t4_first_id", evt_id, 0);
    check("t4_repend", dut.pending[0], 1);
    check("t4_no_drop", dropped[0], 0);
    n_rise = 0;
    prev = 1'b1;
    rise_cyc[0] = -100; rise_id[0] = -1;
    for (int c = 0; c < 40; c++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      if (evt_valid && !prev) begin
        if (n_rise < 1) begin rise_cyc[0] = c; rise_id[0] = int'(evt_id); end
        n_rise++;
      end
      prev = evt_valid;
    end
    check("t4_regrant_count", n_rise, 1);
    check("t4_regrant_id", rise_id[0], 0);
    check("t4_regrant_spacing", rise_cyc[0], GAP + 2);
    check("t4_drop_final", dropped[0], 0);

    $display("[TB] reset during PRESENT and HOLDOFF");
    apply_stimulus(1'b1, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    wait_valid(10, 1'b0);
    check("t6_pre_id", evt_id, 2);
    apply_stimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'b1000, 1'b0, 1'b0);
    check("t6_pre_drop", dropped[3], 1);
    apply_stimulus(1'b1, '0, 1'b0, 1'b0);
    check("t6a_valid", evt_valid, 0);
    check("t6a_pending", dut.pending, 0);
    check("t6a_dropped", dropped, 0);
    apply_stimulus(1'b0, 4'b1001, 1'b1, 1'b0);
    wait_valid(10, 1'b1);
    check("t6a_first_id", evt_id, 0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check("t6b_in_holdoff", evt_valid, 0);
    apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    check("t6b_pre_drop", dropped[2], 1);
    apply_stimulus(1'b1, '0, 1'b1, 1'b0);
    check("t6b_valid", evt_valid, 0);
    check("t6b_pending", dut.pending, 0);
    check("t6b_dropped", dropped, 0);
    apply_stimulus(1'b0, 4'b1001, 1'b1, 1'b0);
    wait_valid(10, 1'b1);
    check("t6b_first_id", evt_id, 0);

    $display("[TB] randomized run");
    apply_stimulus(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic rdy;
      logic clr;
      r = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < N; b++) e[b] = ($urandom_range(0, 9) == 0);
      rdy = ((i / 200) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 29) == 0);
      apply_stimulus(r, e, rdy, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
